life_render: RTL

Display-side reader for the Game of Life board memory: it sits downstream of `life_logic`. Each cycle it maps the VGA timing generator's (hcount, vcount) to a board word address and issues a read on a second memory port. It extracts the cell bit from the returned line and produces a 12-bit pixel, with sync and blank delayed to stay aligned. It also latches which of the two board buffers to display at each frame start and pulses `frame_start_out`, so the logic stage can swap buffers between frames.

---
 rtl/life_render.sv | 139 +++++++++++++
 1 files changed

// File: rtl/life_render.sv
// Display-side reader for the Life board: maps VGA counters to board word reads and
// turns the returned cell bit into an RGB444 pixel, keeping sync/blank aligned.
module life_render #(
    parameter int unsigned ADDR_SIZE    = 32,
    parameter int unsigned LINE_WIDTH   = 8,
    parameter int unsigned BOARD_W      = 64,
    parameter int unsigned BOARD_H      = 64,
    parameter int unsigned LOG_CELL_PX  = 2,
    parameter int unsigned X0           = 192,
    parameter int unsigned Y0           = 112,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blank_in,
    input  logic                  buf_sel_in,
    input  logic [LINE_WIDTH-1:0] data_in,
    output logic [ADDR_SIZE-1:0]  addr_r_out,
    output logic [11:0]           pixel_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  blank_out,
    output logic                  frame_start_out
);

    localparam int unsigned WORDS_PER_ROW = BOARD_W / LINE_WIDTH;
    localparam int unsigned BUF_WORDS     = WORDS_PER_ROW * BOARD_H;
    localparam int unsigned PIPE          = READ_LATENCY + 2;
    localparam int unsigned BIT_W         = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned PIX_W         = BOARD_W << LOG_CELL_PX;
    localparam int unsigned PIX_H         = BOARD_H << LOG_CELL_PX;
    // Delay stages before the output register; the last one lines up with data_in.
    localparam int unsigned STAGES        = PIPE - 1;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             blank;
        logic             in_board;
        logic [BIT_W-1:0] bit_idx;
    } stage_t;

    localparam stage_t STAGE_RST = '{
        hsync:    1'b1,
        vsync:    1'b1,
        blank:    1'b1,
        in_board: 1'b0,
        bit_idx:  '0
    };

    stage_t      pipe_q [STAGES];
    stage_t      cur_d;
    stage_t      sel;
    logic        active_buf_q;
    logic        vsync_prev_q;
    logic        frame_start;
    logic        in_board;
    logic [31:0] hc;
    logic [31:0] vc;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] base;
    logic [31:0] addr_full;
    logic [11:0] pix_d;

    always_comb begin
        hc        = 32'(hcount_in);
        vc        = 32'(vcount_in);
        dx        = hc - X0;
        dy        = vc - Y0;
        // Full-width unsigned compares keep negative offsets from wrapping into the board.
        in_board  = (hc >= X0) && (dx < PIX_W) && (vc >= Y0) && (dy < PIX_H);
        col       = dx >> LOG_CELL_PX;
        row       = dy >> LOG_CELL_PX;
        base      = active_buf_q ? BUF_WORDS : 32'd0;
        addr_full = base + row * WORDS_PER_ROW + col / LINE_WIDTH;

        cur_d.hsync    = hsync_in;
        cur_d.vsync    = vsync_in;
        cur_d.blank    = blank_in;
        cur_d.in_board = in_board;
        cur_d.bit_idx  = BIT_W'(col % LINE_WIDTH);

        frame_start = vsync_prev_q && !vsync_in;
    end

    always_comb begin
        sel = pipe_q[STAGES-1];
        if (sel.blank) begin
            pix_d = 12'h000;
        end else if (!sel.in_board) begin
            pix_d = 12'h222;
        end else if (data_in[sel.bit_idx]) begin
            pix_d = 12'hFFF;
        end else begin
            pix_d = 12'h000;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_r_out      <= '0;
            pixel_out       <= 12'h000;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            blank_out       <= 1'b1;
            frame_start_out <= 1'b0;
            active_buf_q    <= 1'b0;
            vsync_prev_q    <= 1'b1;
            for (int i = 0; i < int'(STAGES); i++) begin
                pipe_q[i] <= STAGE_RST;
            end
        end else begin
            vsync_prev_q    <= vsync_in;
            frame_start_out <= frame_start;
            if (frame_start) begin
                active_buf_q <= buf_sel_in;
            end
            if (in_board) begin
                addr_r_out <= ADDR_SIZE'(addr_full);
            end
            pipe_q[0] <= cur_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            hsync_out <= sel.hsync;
            vsync_out <= sel.vsync;
            blank_out <= sel.blank;
            pixel_out <= pix_d;
        end
    end

endmodule
